// File: rtl/fc_layer_sequencer_if.sv
// Result stream from the fully-connected layer sequencer to its consumer.
//   res_valid : result available (held until accepted)
//   res_ready : consumer accepts the result this cycle
//   res_data  : signed 32-bit neuron result
//   res_idx   : output neuron index of res_data
interface fc_layer_sequencer_if #(
  parameter int CH_W = 10
);
  logic                   res_valid;
  logic                   res_ready;
  logic signed [31:0]     res_data;
  logic        [CH_W-1:0] res_idx;

  modport master (output res_valid, output res_data, output res_idx, input res_ready);
  modport slave  (input res_valid, input res_data, input res_idx, output res_ready);
endinterface

// File: rtl/fc_layer_sequencer.sv
// Runs a fully-connected layer on the pointwise 1x1 engine, one output neuron
// at a time: clear/start the engine, stream in_ch/NUM_MACS activation/weight
// batches from the on-chip buffers, wait (with a watchdog) for the engine
// result, and hand it downstream over res_if.
//   clock, reset_n          : clock, asynchronous active-low reset
//   cfg_in_ch/out_ch, start : job request and configuration
//   busy, done, error       : job status (done/error are single-cycle pulses)
//   act_rd_* / wt_rd_*      : activation / weight buffer reads (1-cycle latency)
//   pw_*                    : pointwise engine control and data
//   res_if (master)         : result stream (valid/ready, data, neuron index)
module fc_layer_sequencer #(
  parameter int NUM_MACS    = 16,
  parameter int CH_W        = 10,
  parameter int ADDR_W      = 12,
  parameter int LOAD_GAP    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [CH_W-1:0]            cfg_in_ch,
  input  logic [CH_W-1:0]            cfg_out_ch,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       act_rd_en,
  output logic [ADDR_W-1:0]          act_rd_addr,
  input  logic [NUM_MACS*8-1:0]      act_rd_data,
  output logic                       wt_rd_en,
  output logic [ADDR_W-1:0]          wt_rd_addr,
  input  logic [NUM_MACS*8-1:0]      wt_rd_data,
  output logic [CH_W-1:0]            pw_in_ch,
  output logic [CH_W-1:0]            pw_out_ch,
  output logic [NUM_MACS*8-1:0]      pw_act,
  output logic [NUM_MACS*8-1:0]      pw_wt,
  output logic                       pw_clear,
  output logic                       pw_start,
  output logic                       pw_load,
  input  logic signed [31:0]         pw_result,
  input  logic                       pw_valid,
  fc_layer_sequencer_if.master       res_if
);

  localparam int DW    = NUM_MACS * 8;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_START, S_FETCH, S_LOAD, S_GAP, S_WAIT_RES, S_OUTPUT
  } state_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           in_ch_q, in_ch_d, out_ch_q, out_ch_d, nb_q, nb_d;
  logic [CH_W-1:0]           b_q, b_d, o_q, o_d;
  logic [ADDR_W-1:0]         wt_base_q, wt_base_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic [DW-1:0]             act_q, act_d, wt_q, wt_d;
  logic signed [31:0]        res_data_q, res_data_d;
  logic [CH_W-1:0]           res_idx_q, res_idx_d;
  logic                      res_valid_q, res_valid_d;
  logic                      done_q, done_d, error_q, error_d;
  logic                      clear_q, clear_d, pstart_q, pstart_d, load_q, load_d;
  logic                      rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]         act_addr_q, act_addr_d, wt_addr_q, wt_addr_d;
  logic [CH_W-1:0]           pw_in_ch_q, pw_in_ch_d, pw_out_ch_q, pw_out_ch_d;

  // Job configuration check on the raw request inputs.
  logic [CH_W-1:0] cfg_nb;
  logic [31:0]     cfg_span;
  logic            cfg_bad;
  logic            batch_end;

  always_comb begin
    cfg_nb   = cfg_in_ch / CH_W'(NUM_MACS);
    cfg_span = 32'(cfg_out_ch) * 32'(cfg_nb);
    cfg_bad  = (cfg_in_ch == '0) || (cfg_out_ch == '0) ||
               ((cfg_in_ch % CH_W'(NUM_MACS)) != '0) ||
               (cfg_span > 32'(1 << ADDR_W));
  end

  always_comb begin
    state_d     = state_q;
    in_ch_d     = in_ch_q;
    out_ch_d    = out_ch_q;
    nb_d        = nb_q;
    b_d         = b_q;
    o_d         = o_q;
    wt_base_d   = wt_base_q;
    gap_d       = gap_q;
    wd_d        = wd_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    batch_end   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            error_d = 1'b1;
          end else begin
            in_ch_d   = cfg_in_ch;
            out_ch_d  = cfg_out_ch;
            nb_d      = cfg_nb;
            o_d       = '0;
            wt_base_d = '0;
            state_d   = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_d = S_START;
      S_START: begin
        b_d     = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (LOAD_GAP == 0) begin
          batch_end = 1'b1;
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(LOAD_GAP - 1)) batch_end = 1'b1;
        else                                gap_d     = gap_q + 1'b1;
      end
      S_WAIT_RES: begin
        // A result arriving on the last watchdog cycle still wins.
        if (pw_valid) begin
          res_data_d  = pw_result;
          res_idx_d   = o_q;
          res_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        if (res_if.res_ready) begin
          res_valid_d = 1'b0;
          if (o_q == out_ch_q - 1'b1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            o_d       = o_q + 1'b1;
            wt_base_d = wt_base_q + ADDR_W'(nb_q);
            state_d   = S_CLEAR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (batch_end) begin
      if (b_q == nb_q - 1'b1) begin
        wd_d    = '0;
        state_d = S_WAIT_RES;
      end else begin
        b_d     = b_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    // Strobes are decoded from the next state so they are flop outputs that
    // line up exactly with the state they belong to.
    clear_d     = (state_d == S_CLEAR);
    pstart_d    = (state_d == S_START);
    rd_en_d     = (state_d == S_FETCH);
    load_d      = (state_d == S_LOAD);
    act_addr_d  = rd_en_d ? ADDR_W'(b_d) : act_addr_q;
    wt_addr_d   = rd_en_d ? (wt_base_d + ADDR_W'(b_d)) : wt_addr_q;
    pw_in_ch_d  = (state_d != S_IDLE) ? in_ch_d : '0;
    pw_out_ch_d = (state_d != S_IDLE) ? CH_W'(1) : '0;

    // Read data is only valid during LOAD; pass it straight to the engine in
    // that cycle and keep it registered until the next LOAD.
    act_d = load_q ? act_rd_data : act_q;
    wt_d  = load_q ? wt_rd_data  : wt_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ch_q     <= '0;
      out_ch_q    <= '0;
      nb_q        <= '0;
      b_q         <= '0;
      o_q         <= '0;
      wt_base_q   <= '0;
      gap_q       <= '0;
      wd_q        <= '0;
      act_q       <= '0;
      wt_q        <= '0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      clear_q     <= 1'b0;
      pstart_q    <= 1'b0;
      load_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      act_addr_q  <= '0;
      wt_addr_q   <= '0;
      pw_in_ch_q  <= '0;
      pw_out_ch_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ch_q     <= in_ch_d;
      out_ch_q    <= out_ch_d;
      nb_q        <= nb_d;
      b_q         <= b_d;
      o_q         <= o_d;
      wt_base_q   <= wt_base_d;
      gap_q       <= gap_d;
      wd_q        <= wd_d;
      act_q       <= act_d;
      wt_q        <= wt_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
      clear_q     <= clear_d;
      pstart_q    <= pstart_d;
      load_q      <= load_d;
      rd_en_q     <= rd_en_d;
      act_addr_q  <= act_addr_d;
      wt_addr_q   <= wt_addr_d;
      pw_in_ch_q  <= pw_in_ch_d;
      pw_out_ch_q <= pw_out_ch_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign error            = error_q;
  assign act_rd_en        = rd_en_q;
  assign wt_rd_en         = rd_en_q;
  assign act_rd_addr      = act_addr_q;
  assign wt_rd_addr       = wt_addr_q;
  assign pw_in_ch         = pw_in_ch_q;
  assign pw_out_ch        = pw_out_ch_q;
  assign pw_act           = act_d;
  assign pw_wt            = wt_d;
  assign pw_clear         = clear_q;
  assign pw_start         = pstart_q;
  assign pw_load          = load_q;
  assign res_if.res_valid = res_valid_q;
  assign res_if.res_data  = res_data_q;
  assign res_if.res_idx   = res_idx_q;

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
Sequences the pointwise 1x1 engine (pointwise_conv1x1_engine) to run a fully-connected layer, for example 512 to 1, or 512 to N outputs.
For each output neuron it:
- clears and starts the engine,
- streams ceil(in_ch/NUM_MACS) activation/weight batches from on-chip buffers (in_ch must be a multiple of NUM_MACS, otherwise the job errors),
- waits for result_valid with a watchdog,
- hands the 32-bit result downstream over a valid/ready handshake.

It sits between the layer controller, the activation/weight SRAMs and the engine.

Parameters:
NUM_MACS, 16, lanes per batch (one 8-bit activation and one 8-bit weight per lane)
CH_W, 10, width of channel-count fields
ADDR_W, 12, buffer address width
LOAD_GAP, 2, idle cycles after each pw_load pulse before the next fetch
TIMEOUT_CYC, 1024, max cycles in WAIT_RES before error

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cfg_in_ch  in  CH_W  input channels; sampled at start
cfg_out_ch  in  CH_W  output neurons; sampled at start
start  in  1  one-cycle job request; ignored unless IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the job completes normally
error  out  1  one-cycle pulse on bad config or timeout
act_rd_en  out  1  activation buffer read strobe
act_rd_addr  out  ADDR_W  activation batch index
act_rd_data  in  NUM_MACS*8  activation word; valid 1 cycle after act_rd_en
wt_rd_en  out  1  weight buffer read strobe
wt_rd_addr  out  ADDR_W  weight batch address
wt_rd_data  in  NUM_MACS*8  weight word; valid 1 cycle after wt_rd_en
pw_in_ch  out  CH_W  to engine num_input_channels
pw_out_ch  out  CH_W  to engine num_output_channels; always 1
pw_act  out  NUM_MACS*8  lane i in bits [8i+7:8i]
pw_wt  out  NUM_MACS*8  lane i in bits [8i+7:8i]
pw_clear  out  1  engine clear pulse
pw_start  out  1  engine start pulse
pw_load  out  1  engine load_data pulse
pw_result  in  32  engine conv_result
pw_valid  in  1  engine result_valid
res_valid  out  1  result available
res_ready  in  1  downstream accept
res_data  out  32  captured signed result
res_idx  out  CH_W  output neuron index of res_data

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE. Every output and internal counter is 0.
- In IDLE, start is accepted. Latch in_ch and out_ch, set nb = in_ch/NUM_MACS.
  - If in_ch==0, out_ch==0, in_ch%NUM_MACS!=0, or out_ch*nb > 2^ADDR_W: pulse error next cycle and stay in IDLE.
- States: IDLE, CLEAR, START, FETCH, LOAD, GAP, WAIT_RES, OUTPUT.
- CLEAR (1 cycle): pw_clear=1.
- START (1 cycle): pw_start=1. Batch counter b=0.
- FETCH (1 cycle): act_rd_en=wt_rd_en=1, act_rd_addr=b, wt_rd_addr=o*nb+b.
- LOAD (1 cycle): pw_act/pw_wt driven from the read data. Registers hold this value until the next LOAD. pw_load=1.
- GAP: lasts LOAD_GAP cycles, or 0 cycles if LOAD_GAP==0. Then:
  - if b==nb-1, go to WAIT_RES;
  - else b++ and go to FETCH.
- Per-batch cadence is 2+LOAD_GAP cycles. There are exactly nb pw_load pulses per neuron.
- WAIT_RES: the watchdog counts from 0.
  - On pw_valid, capture pw_result into res_data, set res_idx=o, go to OUTPUT.
  - If the watchdog reaches TIMEOUT_CYC-1 with no pw_valid: pulse error, go to IDLE, no done.
  - pw_valid seen in any state other than WAIT_RES is ignored.
- OUTPUT: res_valid=1, data held stable until res_ready. On the handshake:
  - if o==out_ch-1, pulse done and go to IDLE;
  - else o++ and go to CLEAR.
  - res_ready asserted in the same cycle res_valid first rises is accepted that cycle.
- pw_in_ch is the latched in_ch and pw_out_ch=1 from start until IDLE. Both are 0 in IDLE.
- All strobes (pw_clear, pw_start, pw_load, rd_en, done, error) are registered, single-cycle, and mutually exclusive.
- start while busy: ignored, with no effect on the job.
- reset_n asserted mid-job: immediate abort to IDLE. No done and no error.

Test Plan:
- in_ch=512, out_ch=1, act lane i = i+1, wt = 1 -> 32 pw_load pulses, 4 cycles apart. act addr runs 0..31, wt addr runs 0..31. res_data=4352, res_idx=0, one done pulse.
- in_ch=32, out_ch=3, wt word for neuron o all = o+1, act lane i = i+1 -> wt addrs 0,1 / 2,3 / 4,5. res_data = 272, 544, 816 with res_idx 0, 1, 2, then done.
- in_ch=20 (not a multiple of 16); also in_ch=0 -> error pulse one cycle after start, busy never rises, no engine strobes.
- Engine model that never asserts pw_valid -> error exactly TIMEOUT_CYC cycles after entering WAIT_RES, then IDLE. A new start afterwards completes normally.
- res_ready held low for 10 cycles -> res_valid and res_data stable. No CLEAR for the next neuron until the handshake. A second start during the stall is ignored.
- reset_n pulled low during batch 5 -> all outputs 0 asynchronously. A fresh job after release produces the correct result.
